// File: rtl/delay_line.sv
// delay_line: runtime-programmable multi-lane delay line with per-sample valid.
// A chain of max_cycle stages shifts on every enabled edge. The output tap is
// selected combinationally by delay_sel, clamped to max_cycle. A tap of zero
// bypasses the chain entirely, and that bypass also works while reset is held.
module delay_line #(
    parameter int data_size = 16,
    parameter int size      = 1,
    parameter int max_cycle = 8,
    localparam int sel_width = $clog2(max_cycle + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      flush,
    input  logic [sel_width-1:0]      delay_sel,
    input  logic                      valid_in,
    input  logic [data_size*size-1:0] bus_in,
    output logic                      valid_out,
    output logic [data_size*size-1:0] bus_out,
    output logic                      busy
);

    localparam int width = data_size * size;

    logic [width-1:0]     stage_data [1:max_cycle];
    logic [max_cycle:1]   stage_valid;
    logic [sel_width-1:0] eff_delay;
    logic                 tap_valid;
    logic [width-1:0]     tap_data;
    logic                 busy_acc;

    // Clamp the requested delay to the depth of the chain
    always_comb begin
        eff_delay = delay_sel;
        if (delay_sel > sel_width'(max_cycle))
            eff_delay = sel_width'(max_cycle);
    end

    // Stage chain: reset/flush clear everything, enable shifts, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 1; k <= max_cycle; k++)
                stage_data[k] <= '0;
            stage_valid <= '0;
        end else if (flush) begin
            for (int unsigned k = 1; k <= max_cycle; k++)
                stage_data[k] <= '0;
            stage_valid <= '0;
        end else if (en) begin
            stage_data[1]  <= bus_in;
            stage_valid[1] <= valid_in;
            for (int unsigned k = 2; k <= max_cycle; k++) begin
                stage_data[k]  <= stage_data[k-1];
                stage_valid[k] <= stage_valid[k-1];
            end
        end
    end

    // Tap mux and occupancy of stages 1..eff_delay
    always_comb begin
        tap_valid = 1'b0;
        tap_data  = '0;
        busy_acc  = 1'b0;
        for (int unsigned k = 1; k <= max_cycle; k++) begin
            if (k == 32'(eff_delay)) begin
                tap_valid = stage_valid[k];
                tap_data  = stage_data[k];
            end
            if (k <= 32'(eff_delay))
                busy_acc = busy_acc | stage_valid[k];
        end
    end

    // Output select: bypass for zero delay, otherwise the zero-masked tap
    always_comb begin
        if (eff_delay == '0) begin
            valid_out = valid_in;
            bus_out   = valid_in ? bus_in : '0;
            busy      = 1'b0;
        end else begin
            valid_out = tap_valid;
            bus_out   = tap_valid ? tap_data : '0;
            busy      = busy_acc;
        end
    end

endmodule

// File: tb/tb_delay_line.sv
// tb_delay_line: directed scenarios plus random traffic against a sample-history model.
module tb_delay_line;

    localparam int DS = 16;
    localparam int SZ = 2;
    localparam int MC = 8;
    localparam int SW = 4;
    localparam int W  = DS * SZ;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          flush;
    logic [SW-1:0] delay_sel;
    logic          valid_in;
    logic [W-1:0]  bus_in;
    logic          valid_out;
    logic [W-1:0]  bus_out;
    logic          busy;

    always #5 clk = ~clk;

    delay_line #(
        .data_size(DS),
        .size(SZ),
        .max_cycle(MC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .flush(flush),
        .delay_sel(delay_sel),
        .valid_in(valid_in),
        .bus_in(bus_in),
        .valid_out(valid_out),
        .bus_out(bus_out),
        .busy(busy)
    );

    typedef struct {
        logic         v;
        logic [W-1:0] d;
    } samp_t;

    // hist[i] is the sample captured i+1 enabled edges ago
    samp_t hist[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic         obs_v;
    logic         obs_b;
    logic [W-1:0] obs_d;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_clear();
        samp_t z;
        z.v = 1'b0;
        z.d = '0;
        hist.delete();
        for (int i = 0; i < MC; i++) hist.push_back(z);
    endtask

    // One clock cycle: drive after negedge, compare against the model, then
    // advance the model at the posedge.
    task automatic step(input logic r, input logic e, input logic f, input logic v,
                        input logic [W-1:0] d, input logic [SW-1:0] sel, input string tag);
        int           eff;
        samp_t        s;
        logic         ev;
        logic         eb;
        logic [W-1:0] ed;
        @(negedge clk);
        rst_n     = r;
        en        = e;
        flush     = f;
        valid_in  = v;
        bus_in    = d;
        delay_sel = sel;
        if (!r) model_clear();
        eff = int'(sel);
        if (eff > MC) eff = MC;
        eb = 1'b0;
        if (eff == 0) begin
            ev = v;
            ed = v ? d : '0;
        end else begin
            s  = hist[eff-1];
            ev = s.v;
            ed = s.v ? s.d : '0;
            for (int i = 0; i < eff; i++) if (hist[i].v) eb = 1'b1;
        end
        #1;
        obs_v = valid_out;
        obs_d = bus_out;
        obs_b = busy;
        check({tag, ".valid"}, W'(obs_v), W'(ev));
        check({tag, ".bus"},   obs_d,     ed);
        check({tag, ".busy"},  W'(obs_b), W'(eb));
        @(posedge clk);
        if (!r || f) begin
            model_clear();
        end else if (e) begin
            s.v = v;
            s.d = d;
            hist.push_front(s);
            void'(hist.pop_back());
        end
    endtask

    logic [W-1:0] lat_w [3];
    logic [W-1:0] chg_w [5];

    initial begin
        logic          r, e, f, v;
        logic [W-1:0]  d;
        logic [SW-1:0] sel;

        lat_w = '{32'h0001_0002, 32'h0003_0004, 32'h0005_0006};
        chg_w = '{32'd7, 32'd8, 32'd7, 32'd8, 32'd9};
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; valid_in = 1'b0;
        bus_in = '0; delay_sel = '0;
        model_clear();

        // Reset state with a nonzero delay: everything quiet
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 32'h1111_2222, 4'd3, "reset");
            check("reset_const.valid", W'(obs_v), '0);
            check("reset_const.bus", obs_d, '0);
        end

        // Basic latency of 3
        for (int c = 0; c < 8; c++) begin
            d = (c < 3) ? lat_w[c] : '0;
            step(1'b1, 1'b1, 1'b0, c < 3, d, 4'd3, "latency");
            if (c >= 3 && c <= 5) begin
                check("latency_const.bus", obs_d, lat_w[c-3]);
                check("latency_const.valid", W'(obs_v), W'(1));
            end else begin
                check("latency_const.idle", W'(obs_v), '0);
            end
        end

        // Stall: A on cycle 0, en low for cycles 1..3
        for (int c = 0; c < 7; c++) begin
            e = !(c >= 1 && c <= 3);
            v = (c == 0) || (c >= 1 && c <= 3);
            d = (c == 0) ? 32'hA5A5_0A0A : 32'hDEAD_0000 + W'(c);
            step(1'b1, e, 1'b0, v, d, 4'd2, "stall");
            if (c == 5) check("stall_const.bus", obs_d, 32'hA5A5_0A0A);
            if (c == 4) check("stall_const.early", W'(obs_v), '0);
        end

        // Flush wins over en and drops the sample presented with it
        for (int c = 0; c < 13; c++) begin
            f = (c == 3);
            v = (c <= 3);
            d = (c == 3) ? 32'h0000_BEEF : 32'h0100_0000 + W'(c);
            step(1'b1, 1'b1, f, v, d, 4'd4, "flush");
            if (c >= 4) begin
                check("flush_const.valid", W'(obs_v), '0);
                check("flush_const.busy", W'(obs_b), '0);
                check("flush_const.bus", obs_d, '0);
            end
        end

        // Bypass, also while reset is held
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 4'd0, "bypass");
        check("bypass_const.bus", obs_d, 32'h0000_1234);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 4'd0, "bypass_rst");
        check("bypass_rst_const.bus", obs_d, 32'h0000_1234);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, 4'd0, "bypass_rel");

        // Clamp: delay_sel=15 behaves as 8
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b1, 1'b0, c == 0, (c == 0) ? 32'h00C1_00A5 : '0, 4'd15, "clamp");
            if (c == 7) check("clamp_const.early", W'(obs_v), '0);
            if (c == 8) check("clamp_const.bus", obs_d, 32'h00C1_00A5);
        end

        // Async reset with three samples in flight
        for (int c = 0; c < 3; c++)
            step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0200_0000 + W'(c), 4'd3, "inflight");
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 4'd3, "async_rst");
        check("async_rst_const.valid", W'(obs_v), '0);
        check("async_rst_const.busy", W'(obs_b), '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 4'd3, "async_rst_hold");
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, '0, 4'd3, "post_rst");
            check("post_rst_const.valid", W'(obs_v), '0);
        end

        // Delay change 2 -> 4 after cycle 10, back to 2 after cycle 20
        for (int c = 0; c < 25; c++) begin
            sel = (c <= 10) ? 4'd2 : (c <= 20) ? 4'd4 : 4'd2;
            step(1'b1, 1'b1, 1'b0, 1'b1, W'(c), sel, "dchange");
            if (c >= 9 && c <= 13) check("dchange_const.reemit", obs_d, chg_w[c-9]);
            if (c == 21) check("dchange_const.skip", obs_d, 32'd19);
        end

        // Random traffic
        sel = 4'd3;
        for (int c = 0; c < 500; c++) begin
            r = ($urandom_range(0, 59) != 0);
            e = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 24) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = $urandom;
            if ($urandom_range(0, 9) == 0) sel = SW'($urandom_range(0, 15));
            step(r, e, f, v, d, sel, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
